// File: rtl/bitrev_reorder.sv
// bitrev_reorder: ping-pong buffer that turns a bit-reversed FFT output stream
// into gap-free natural-order frames.
module bitrev_reorder #(
  parameter int N = 32,
  parameter int LOG2N = 5,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_i,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last
);
  typedef enum logic {IDLE, READ} state_t;
  state_t state;
  logic [2*WIDTH-1:0] mem [2*N];
  logic [LOG2N-1:0] wr_cnt, rd_cnt, wr_rev;
  logic wr_bank, rd_bank, launch;
  genvar g;
  for (g = 0; g < LOG2N; g++) begin : g_rev
    assign wr_rev[g] = wr_cnt[LOG2N-1-g];
  end
  assign launch = in_valid && wr_cnt == LOG2N'(N-1);
  // Bank storage is deliberately left unreset; only the counters define frame validity.
  always_ff @(posedge clk)
    if (in_valid && !rst) mem[{wr_bank, wr_rev}] <= {in_r, in_i};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      rd_cnt <= '0;
      rd_bank <= 1'b0;
      state <= IDLE;
      out_valid <= 1'b0;
      {out_r, out_i} <= '0;
      out_index <= '0;
      out_last <= 1'b0;
    end else begin
      if (in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (launch) wr_bank <= ~wr_bank;
      end
      out_valid <= state == READ;
      {out_r, out_i} <= state == READ ? mem[{rd_bank, rd_cnt}] : '0;
      out_index <= state == READ ? rd_cnt : '0;
      out_last <= state == READ && rd_cnt == LOG2N'(N-1);
      if (launch) begin
        state <= READ;
        rd_cnt <= '0;
        rd_bank <= wr_bank;
      end else if (state == READ) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == LOG2N'(N-1)) state <= IDLE;
      end
    end
  end
endmodule
